// File: rtl/tlul_arb_pkg.sv
// Shared types and default widths for the 2:1 TL-UL master arbiter.
package tlul_arb_pkg;

  localparam int unsigned DefAddrWidth   = 32;
  localparam int unsigned DefDataWidth   = 32;
  localparam int unsigned DefSizeWidth   = 3;
  localparam int unsigned DefOpcodeWidth = 3;
  localparam int unsigned DefParamWidth  = 3;
  localparam int unsigned DefMaxOutst    = 4;

  // A-channel arbitration state
  typedef enum logic {
    StArb  = 1'b0,
    StHold = 1'b1
  } arb_state_e;

  // One in-flight request: which master issued it and its original a_source
  typedef struct packed {
    logic master_id;
    logic orig_source;
  } id_entry_t;

  localparam int unsigned IdEntryWidth = $bits(id_entry_t);

endpackage

// File: rtl/tlul_id_fifo.sv
// In-order ID FIFO recording {master_id, orig_source} per accepted A beat.
// Pointers carry one extra wrap bit so full/empty are told apart without a counter.
module tlul_id_fifo
  import tlul_arb_pkg::*;
#(
  parameter int unsigned Depth = DefMaxOutst,
  parameter int unsigned Width = IdEntryWidth
) (
  input  logic             clk_24,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]  wr_q, rd_q;
  logic [Width-1:0] mem_q [Depth];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AddrW] != rd_q[AddrW]) && (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]);
  assign dout  = mem_q[rd_q[AddrW-1:0]];

  // Pointer and storage update; push/pop are ignored when they would over/underflow
  always_ff @(posedge clk_24) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        mem_q[wr_q[AddrW-1:0]] <= din;
        wr_q                   <= wr_q + PtrW'(1);
      end
      if (pop && !empty) begin
        rd_q <= rd_q + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/tlul_master_arbiter.sv
// 2:1 TL-UL master arbiter: round-robin on channel A with a grant lock while the
// downstream stalls, a_source rewritten to the winning master index, and channel D
// steered back through an in-order ID FIFO.
// Optional macro TLUL_ARB_STATS_EN adds saturating grant/stall counters.
module tlul_master_arbiter
  import tlul_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SIZE_WIDTH   = DefSizeWidth,
  parameter int unsigned OPCODE_WIDTH = DefOpcodeWidth,
  parameter int unsigned PARAM_WIDTH  = DefParamWidth,
  parameter int unsigned MAX_OUTST    = DefMaxOutst
) (
  input  logic                    clk_24,
  input  logic                    reset,
  // Requester 0
  input  logic                    m0_a_valid,
  output logic                    m0_a_ready,
  input  logic [OPCODE_WIDTH-1:0] m0_a_opcode,
  input  logic [PARAM_WIDTH-1:0]  m0_a_param,
  input  logic [SIZE_WIDTH-1:0]   m0_a_size,
  input  logic                    m0_a_source,
  input  logic [ADDR_WIDTH-1:0]   m0_a_address,
  input  logic [MASK_WIDTH-1:0]   m0_a_mask,
  input  logic [DATA_WIDTH-1:0]   m0_a_data,
  output logic                    m0_d_valid,
  input  logic                    m0_d_ready,
  output logic [OPCODE_WIDTH-1:0] m0_d_opcode,
  output logic [PARAM_WIDTH-1:0]  m0_d_param,
  output logic [SIZE_WIDTH-1:0]   m0_d_size,
  output logic                    m0_d_source,
  output logic                    m0_d_sink,
  output logic [DATA_WIDTH-1:0]   m0_d_data,
  output logic                    m0_d_error,
  // Requester 1
  input  logic                    m1_a_valid,
  output logic                    m1_a_ready,
  input  logic [OPCODE_WIDTH-1:0] m1_a_opcode,
  input  logic [PARAM_WIDTH-1:0]  m1_a_param,
  input  logic [SIZE_WIDTH-1:0]   m1_a_size,
  input  logic                    m1_a_source,
  input  logic [ADDR_WIDTH-1:0]   m1_a_address,
  input  logic [MASK_WIDTH-1:0]   m1_a_mask,
  input  logic [DATA_WIDTH-1:0]   m1_a_data,
  output logic                    m1_d_valid,
  input  logic                    m1_d_ready,
  output logic [OPCODE_WIDTH-1:0] m1_d_opcode,
  output logic [PARAM_WIDTH-1:0]  m1_d_param,
  output logic [SIZE_WIDTH-1:0]   m1_d_size,
  output logic                    m1_d_source,
  output logic                    m1_d_sink,
  output logic [DATA_WIDTH-1:0]   m1_d_data,
  output logic                    m1_d_error,
  // Shared downstream socket
  output logic                    s_a_valid,
  input  logic                    s_a_ready,
  output logic [OPCODE_WIDTH-1:0] s_a_opcode,
  output logic [PARAM_WIDTH-1:0]  s_a_param,
  output logic [SIZE_WIDTH-1:0]   s_a_size,
  output logic                    s_a_source,
  output logic [ADDR_WIDTH-1:0]   s_a_address,
  output logic [MASK_WIDTH-1:0]   s_a_mask,
  output logic [DATA_WIDTH-1:0]   s_a_data,
  input  logic                    s_d_valid,
  output logic                    s_d_ready,
  input  logic [OPCODE_WIDTH-1:0] s_d_opcode,
  input  logic [PARAM_WIDTH-1:0]  s_d_param,
  input  logic [SIZE_WIDTH-1:0]   s_d_size,
  input  logic                    s_d_source,
  input  logic                    s_d_sink,
  input  logic [DATA_WIDTH-1:0]   s_d_data,
  input  logic                    s_d_error,
`ifdef TLUL_ARB_STATS_EN
  output logic [31:0]             stat_grant_m0,
  output logic [31:0]             stat_grant_m1,
  output logic [31:0]             stat_stall,
`endif
  output logic                    err_spurious
);

  logic [1:0] a_valid;
  assign a_valid = {m1_a_valid, m0_a_valid};

  arb_state_e state_q, state_d;
  logic       lock_q, lock_d;
  logic       rr_q, rr_d;
  logic       err_q, err_d;
  logic       grant, gnt_vld, fire;

  logic       fifo_full, fifo_empty, fifo_pop;
  id_entry_t  push_entry, head_entry;

  // Arbitration FSM: pick in ARB, freeze the winner in HOLD until the slave accepts
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    grant   = rr_q;
    gnt_vld = 1'b0;
    unique case (state_q)
      StArb: begin
        // Fullness gates only new grants; a held beat is already accounted for
        if (!fifo_full) begin
          if (a_valid[rr_q]) begin
            grant   = rr_q;
            gnt_vld = 1'b1;
          end else if (a_valid[~rr_q]) begin
            grant   = ~rr_q;
            gnt_vld = 1'b1;
          end
        end
        if (gnt_vld && !s_a_ready) begin
          state_d = StHold;
          lock_d  = grant;
        end
      end
      StHold: begin
        grant   = lock_q;
        gnt_vld = a_valid[lock_q];
        if (gnt_vld && s_a_ready) begin
          state_d = StArb;
        end
      end
      default: state_d = StArb;
    endcase
    // Outputs stay quiet while reset is held
    if (!reset) begin
      gnt_vld = 1'b0;
    end
  end

  assign fire       = gnt_vld & s_a_ready;
  assign rr_d       = fire ? ~grant : rr_q;
  assign m0_a_ready = fire & (grant == 1'b0);
  assign m1_a_ready = fire & (grant == 1'b1);
  assign s_a_valid  = gnt_vld;

  assign push_entry.master_id   = grant;
  assign push_entry.orig_source = grant ? m1_a_source : m0_a_source;

  // A-channel field mux toward the slave; source becomes the master index
  always_comb begin
    s_a_opcode  = '0;
    s_a_param   = '0;
    s_a_size    = '0;
    s_a_source  = 1'b0;
    s_a_address = '0;
    s_a_mask    = '0;
    s_a_data    = '0;
    if (gnt_vld) begin
      s_a_source = grant;
      if (grant) begin
        s_a_opcode  = m1_a_opcode;
        s_a_param   = m1_a_param;
        s_a_size    = m1_a_size;
        s_a_address = m1_a_address;
        s_a_mask    = m1_a_mask;
        s_a_data    = m1_a_data;
      end else begin
        s_a_opcode  = m0_a_opcode;
        s_a_param   = m0_a_param;
        s_a_size    = m0_a_size;
        s_a_address = m0_a_address;
        s_a_mask    = m0_a_mask;
        s_a_data    = m0_a_data;
      end
    end
  end

  // D-channel steering by FIFO head; with no owner the beat is sunk and flagged
  always_comb begin
    m0_d_valid  = 1'b0;
    m0_d_opcode = '0;
    m0_d_param  = '0;
    m0_d_size   = '0;
    m0_d_source = 1'b0;
    m0_d_sink   = 1'b0;
    m0_d_data   = '0;
    m0_d_error  = 1'b0;
    m1_d_valid  = 1'b0;
    m1_d_opcode = '0;
    m1_d_param  = '0;
    m1_d_size   = '0;
    m1_d_source = 1'b0;
    m1_d_sink   = 1'b0;
    m1_d_data   = '0;
    m1_d_error  = 1'b0;
    s_d_ready   = 1'b0;
    if (reset) begin
      if (fifo_empty) begin
        s_d_ready = s_d_valid;
      end else if (head_entry.master_id) begin
        m1_d_valid  = s_d_valid;
        m1_d_opcode = s_d_opcode;
        m1_d_param  = s_d_param;
        m1_d_size   = s_d_size;
        m1_d_source = head_entry.orig_source;
        m1_d_sink   = s_d_sink;
        m1_d_data   = s_d_data;
        m1_d_error  = s_d_error;
        s_d_ready   = m1_d_ready;
      end else begin
        m0_d_valid  = s_d_valid;
        m0_d_opcode = s_d_opcode;
        m0_d_param  = s_d_param;
        m0_d_size   = s_d_size;
        m0_d_source = head_entry.orig_source;
        m0_d_sink   = s_d_sink;
        m0_d_data   = s_d_data;
        m0_d_error  = s_d_error;
        s_d_ready   = m0_d_ready;
      end
    end
  end

  assign fifo_pop     = s_d_valid & s_d_ready & ~fifo_empty;
  assign err_d        = s_d_valid & fifo_empty & reset;
  assign err_spurious = err_q;

  tlul_id_fifo #(
    .Depth (MAX_OUTST),
    .Width (IdEntryWidth)
  ) u_id_fifo (
    .clk_24 (clk_24),
    .reset  (reset),
    .push   (fire),
    .pop    (fifo_pop),
    .din    (push_entry),
    .dout   (head_entry),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Arbiter state, lock, round-robin pointer and spurious-beat pulse
  always_ff @(posedge clk_24) begin
    if (!reset) begin
      state_q <= StArb;
      lock_q  <= 1'b0;
      rr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

`ifdef TLUL_ARB_STATS_EN
  logic [31:0] grant_m0_q, grant_m1_q, stall_q;
  logic        stall;

  assign stall         = (|a_valid) & ~fire & reset;
  assign stat_grant_m0 = grant_m0_q;
  assign stat_grant_m1 = grant_m1_q;
  assign stat_stall    = stall_q;

  // Saturating per-master grant counters and stall-cycle counter
  always_ff @(posedge clk_24) begin
    if (!reset) begin
      grant_m0_q <= '0;
      grant_m1_q <= '0;
      stall_q    <= '0;
    end else begin
      if (m0_a_ready && (grant_m0_q != '1)) grant_m0_q <= grant_m0_q + 32'd1;
      if (m1_a_ready && (grant_m1_q != '1)) grant_m1_q <= grant_m1_q + 32'd1;
      if (stall && (stall_q != '1))         stall_q    <= stall_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tlul_master_arbiter.sv
// Directed bench for tlul_master_arbiter with hand-computed expectations.
module tb_tlul_master_arbiter;

  logic        clk_24 = 1'b0;
  logic        reset;
  logic        m0_a_valid, m0_a_ready, m0_a_source;
  logic [2:0]  m0_a_opcode, m0_a_param, m0_a_size;
  logic [31:0] m0_a_address, m0_a_data;
  logic [3:0]  m0_a_mask;
  logic        m0_d_valid, m0_d_ready, m0_d_source, m0_d_sink, m0_d_error;
  logic [2:0]  m0_d_opcode, m0_d_param, m0_d_size;
  logic [31:0] m0_d_data;
  logic        m1_a_valid, m1_a_ready, m1_a_source;
  logic [2:0]  m1_a_opcode, m1_a_param, m1_a_size;
  logic [31:0] m1_a_address, m1_a_data;
  logic [3:0]  m1_a_mask;
  logic        m1_d_valid, m1_d_ready, m1_d_source, m1_d_sink, m1_d_error;
  logic [2:0]  m1_d_opcode, m1_d_param, m1_d_size;
  logic [31:0] m1_d_data;
  logic        s_a_valid, s_a_ready, s_a_source;
  logic [2:0]  s_a_opcode, s_a_param, s_a_size;
  logic [31:0] s_a_address, s_a_data;
  logic [3:0]  s_a_mask;
  logic        s_d_valid, s_d_ready, s_d_source, s_d_sink, s_d_error;
  logic [2:0]  s_d_opcode, s_d_param, s_d_size;
  logic [31:0] s_d_data;
  logic        err_spurious;
`ifdef TLUL_ARB_STATS_EN
  logic [31:0] stat_grant_m0, stat_grant_m1, stat_stall;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk_24 = ~clk_24;

  tlul_master_arbiter u_dut (
    .clk_24       (clk_24),
    .reset        (reset),
    .m0_a_valid   (m0_a_valid),
    .m0_a_ready   (m0_a_ready),
    .m0_a_opcode  (m0_a_opcode),
    .m0_a_param   (m0_a_param),
    .m0_a_size    (m0_a_size),
    .m0_a_source  (m0_a_source),
    .m0_a_address (m0_a_address),
    .m0_a_mask    (m0_a_mask),
    .m0_a_data    (m0_a_data),
    .m0_d_valid   (m0_d_valid),
    .m0_d_ready   (m0_d_ready),
    .m0_d_opcode  (m0_d_opcode),
    .m0_d_param   (m0_d_param),
    .m0_d_size    (m0_d_size),
    .m0_d_source  (m0_d_source),
    .m0_d_sink    (m0_d_sink),
    .m0_d_data    (m0_d_data),
    .m0_d_error   (m0_d_error),
    .m1_a_valid   (m1_a_valid),
    .m1_a_ready   (m1_a_ready),
    .m1_a_opcode  (m1_a_opcode),
    .m1_a_param   (m1_a_param),
    .m1_a_size    (m1_a_size),
    .m1_a_source  (m1_a_source),
    .m1_a_address (m1_a_address),
    .m1_a_mask    (m1_a_mask),
    .m1_a_data    (m1_a_data),
    .m1_d_valid   (m1_d_valid),
    .m1_d_ready   (m1_d_ready),
    .m1_d_opcode  (m1_d_opcode),
    .m1_d_param   (m1_d_param),
    .m1_d_size    (m1_d_size),
    .m1_d_source  (m1_d_source),
    .m1_d_sink    (m1_d_sink),
    .m1_d_data    (m1_d_data),
    .m1_d_error   (m1_d_error),
    .s_a_valid    (s_a_valid),
    .s_a_ready    (s_a_ready),
    .s_a_opcode   (s_a_opcode),
    .s_a_param    (s_a_param),
    .s_a_size     (s_a_size),
    .s_a_source   (s_a_source),
    .s_a_address  (s_a_address),
    .s_a_mask     (s_a_mask),
    .s_a_data     (s_a_data),
    .s_d_valid    (s_d_valid),
    .s_d_ready    (s_d_ready),
    .s_d_opcode   (s_d_opcode),
    .s_d_param    (s_d_param),
    .s_d_size     (s_d_size),
    .s_d_source   (s_d_source),
    .s_d_sink     (s_d_sink),
    .s_d_data     (s_d_data),
    .s_d_error    (s_d_error),
`ifdef TLUL_ARB_STATS_EN
    .stat_grant_m0 (stat_grant_m0),
    .stat_grant_m1 (stat_grant_m1),
    .stat_stall    (stat_stall),
`endif
    .err_spurious (err_spurious)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_24);
    #1;
  endtask

  task automatic idle();
    m0_a_valid = 0; m0_a_opcode = 0; m0_a_param = 0; m0_a_size = 0; m0_a_source = 0;
    m0_a_address = 0; m0_a_mask = 0; m0_a_data = 0; m0_d_ready = 0;
    m1_a_valid = 0; m1_a_opcode = 0; m1_a_param = 0; m1_a_size = 0; m1_a_source = 0;
    m1_a_address = 0; m1_a_mask = 0; m1_a_data = 0; m1_d_ready = 0;
    s_a_ready = 0; s_d_valid = 0; s_d_opcode = 0; s_d_param = 0; s_d_size = 0;
    s_d_source = 0; s_d_sink = 0; s_d_data = 0; s_d_error = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic prev_g;
  logic exp_g;

  initial begin
    // Reset: outputs quiet even with live inputs
    idle();
    reset = 0;
    m0_a_valid = 1; s_a_ready = 1; s_d_valid = 1;
    #2;
    chk("rst_s_a_valid", s_a_valid, 0);
    chk("rst_m0_a_ready", m0_a_ready, 0);
    chk("rst_s_d_ready", s_d_ready, 0);
    tick();
    reset = 1;
    idle();
    #1;
    chk("post_rst_s_a_valid", s_a_valid, 0);
    chk("post_rst_a_ready", {m1_a_ready, m0_a_ready}, 2'b00);
    chk("post_rst_s_d_ready", s_d_ready, 0);
    chk("post_rst_d_valid", {m1_d_valid, m0_d_valid}, 2'b00);
    chk("post_rst_err", err_spurious, 0);
    chk("post_rst_s_a_addr", s_a_address, 0);
`ifdef TLUL_ARB_STATS_EN
    chk("post_rst_stat_m0", stat_grant_m0, 0);
`endif

    // Single m0 Get, addr 0x10, src 1
    m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_address = 32'h10; m0_a_source = 1;
    m0_a_mask = 4'hf; s_a_ready = 1;
    #1;
    chk("get_s_a_valid", s_a_valid, 1);
    chk("get_s_a_source", s_a_source, 0);
    chk("get_s_a_addr", s_a_address, 32'h10);
    chk("get_s_a_opcode", s_a_opcode, 3'd4);
    chk("get_a_ready", {m1_a_ready, m0_a_ready}, 2'b01);
    tick();
    idle();
    s_d_valid = 1; s_d_opcode = 3'd1; s_d_data = 32'hA5A5A5A5; s_d_source = 0;
    m0_d_ready = 1;
    #1;
    chk("get_d_valid", {m1_d_valid, m0_d_valid}, 2'b01);
    chk("get_d_data", m0_d_data, 32'hA5A5A5A5);
    chk("get_d_source", m0_d_source, 1);
    chk("get_d_opcode", m0_d_opcode, 3'd1);
    chk("get_s_d_ready", s_d_ready, 1);
    tick();
    idle();
    #1;
    chk("get_err_none", err_spurious, 0);

    // Both valid, 8 beats; rr pointer is 1 after the m0 grant, so m1 leads
    m0_a_valid = 1; m0_a_address = 32'h100; m0_a_source = 0;
    m1_a_valid = 1; m1_a_address = 32'h200; m1_a_source = 1;
    s_a_ready = 1; m0_d_ready = 1; m1_d_ready = 1;
    prev_g = 0;
    for (int k = 0; k < 8; k++) begin
      s_d_valid = (k > 0);
      s_d_data  = 32'h1000 + k;
      #1;
      exp_g = (k % 2 == 0);
      chk("rr_s_a_source", s_a_source, exp_g);
      chk("rr_s_a_addr", s_a_address, exp_g ? 32'h200 : 32'h100);
      if (k > 0) begin
        chk("rr_d_route", {m1_d_valid, m0_d_valid}, prev_g ? 2'b10 : 2'b01);
        chk("rr_d_source", prev_g ? m1_d_source : m0_d_source, prev_g);
      end
      prev_g = exp_g;
      tick();
    end
    m0_a_valid = 0; m1_a_valid = 0; s_d_valid = 1;
    #1;
    chk("rr_drain_route", {m1_d_valid, m0_d_valid}, 2'b01);
    tick();
    idle();
`ifdef TLUL_ARB_STATS_EN
    chk("stat_m0", stat_grant_m0, 5);
    chk("stat_m1", stat_grant_m1, 4);
`endif

    // Hold: m1 wins (rr=1) and stalls 3 cycles while m0 waits
    m0_a_valid = 1; m0_a_address = 32'h300; m0_a_source = 0;
    m1_a_valid = 1; m1_a_address = 32'h400; m1_a_source = 1;
    s_a_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_s_a_valid", s_a_valid, 1);
      chk("hold_s_a_addr", s_a_address, 32'h400);
      chk("hold_s_a_source", s_a_source, 1);
      chk("hold_a_ready", {m1_a_ready, m0_a_ready}, 2'b00);
      tick();
    end
    s_a_ready = 1;
    #1;
    chk("hold_fire", {m1_a_ready, m0_a_ready}, 2'b10);
    chk("hold_fire_addr", s_a_address, 32'h400);
    tick();
    m1_a_valid = 0;
    #1;
    chk("hold_next_src", s_a_source, 0);
    chk("hold_next_ready", {m1_a_ready, m0_a_ready}, 2'b01);
    tick();

    // Fill to 4 outstanding, then the 5th is blocked until a pop
    m1_a_valid = 1; m0_a_address = 32'h500; m1_a_address = 32'h600;
    #1;
    chk("fill3_src", s_a_source, 1);
    tick();
    #1;
    chk("fill4_src", s_a_source, 0);
    tick();
    #1;
    chk("full_s_a_valid", s_a_valid, 0);
    chk("full_a_ready", {m1_a_ready, m0_a_ready}, 2'b00);
    tick();
    s_d_valid = 1; s_d_data = 32'h11; m1_d_ready = 1;
    #1;
    chk("full_pop_route", {m1_d_valid, m0_d_valid}, 2'b10);
    chk("full_pop_src", m1_d_source, 1);
    chk("full_pop_s_a_valid", s_a_valid, 0);
    tick();
    s_d_valid = 0;
    #1;
    chk("after_pop_valid", s_a_valid, 1);
    chk("after_pop_src", s_a_source, 1);
    chk("after_pop_ready", {m1_a_ready, m0_a_ready}, 2'b10);
    tick();
    idle();

    // Reset with outstanding IDs: next D beat is spurious
    reset = 0;
    tick();
    reset = 1;
    s_d_valid = 1; s_d_data = 32'h22;
    #1;
    chk("spur_s_d_ready", s_d_ready, 1);
    chk("spur_d_valid", {m1_d_valid, m0_d_valid}, 2'b00);
    chk("spur_err_early", err_spurious, 0);
    tick();
    s_d_valid = 0;
    #1;
    chk("spur_err_pulse", err_spurious, 1);
    tick();
    chk("spur_err_clear", err_spurious, 0);

    // rr pointer back at 0 after reset
    m0_a_valid = 1; m1_a_valid = 1; s_a_ready = 1;
    #1;
    chk("rst_rr_src", s_a_source, 0);
    tick();
    idle();
`ifdef TLUL_ARB_STATS_EN
    chk("stat_m0_after_rst", stat_grant_m0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
